// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Owns the fetch PC and sequences control-flow redirects resolved in EX.
//   A taken, word-aligned target is loaded into the PC. A misaligned target
//   sends fetch to TRAP_VEC and sets a sticky error flag. In both cases the
//   IF/ID and ID/EX squash signals stay high for FLUSH_CYCLES cycles. While
//   that window is open, further redirects are ignored. A redirect wins over
//   a load-use stall on the same cycle. Two saturating counters track
//   accepted redirects and flush cycles.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   stall        hazard-unit stall: hold the PC
//   ex_valid     EX holds a real (non-bubble) instruction
//   br_taken     branch unit says the control transfer is taken
//   br_target    branch unit target address (32 bits; low PC_W bits used)
//   pc           registered fetch PC
//   flush_if_id  registered squash for the IF/ID register
//   flush_id_ex  registered squash for the ID/EX register
//   in_flush     high while in the FLUSH or TRAP state
//   misalign_err sticky: a taken target had nonzero low two bits
//   taken_cnt    accepted (aligned) redirects, saturating
//   flush_cnt    cycles with the flushes asserted, saturating
module pc_redirect_ctrl #(
  parameter int              PC_W         = 9,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0] TRAP_VEC     = '0,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [PC_W-1:0]  pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             in_flush,
  output logic             misalign_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_t;

  // The window counter is loaded with FLUSH_CYCLES-1. The window closes on
  // the edge where the counter is already zero, so the flushes stay high for
  // exactly FLUSH_CYCLES cycles.
  localparam logic [2:0]      FCNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [PC_W-1:0] PC_STEP   = PC_W'(4);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t           r_state;
  logic [2:0]       r_fcnt;
  logic [PC_W-1:0]  r_pc;
  logic             r_flush;
  logic             r_misalign;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  state_t           w_state_nxt;
  logic [2:0]       w_fcnt_nxt;
  logic [PC_W-1:0]  w_pc_nxt;
  logic             w_flush_nxt;
  logic             w_misalign_nxt;
  logic [CNT_W-1:0] w_taken_cnt_nxt;
  logic [CNT_W-1:0] w_flush_cnt_nxt;

  logic             w_redirect;
  logic             w_aligned;
  logic [PC_W-1:0]  w_pc_seq;

  // Target bits above the PC width are dropped on purpose.
  logic w_unused;
  assign w_unused = &{1'b0, br_target[31:PC_W]};

  assign w_redirect = ex_valid & br_taken;
  assign w_aligned  = (br_target[1:0] == 2'b00);
  assign w_pc_seq   = stall ? r_pc : r_pc + PC_STEP;

  // State register and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_fcnt      <= '0;
      r_pc        <= '0;
      r_flush     <= 1'b0;
      r_misalign  <= 1'b0;
      r_taken_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_fcnt      <= w_fcnt_nxt;
      r_pc        <= w_pc_nxt;
      r_flush     <= w_flush_nxt;
      r_misalign  <= w_misalign_nxt;
      r_taken_cnt <= w_taken_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_fcnt_nxt      = r_fcnt;
    w_pc_nxt        = w_pc_seq;
    w_flush_nxt     = r_flush;
    w_misalign_nxt  = r_misalign;
    w_taken_cnt_nxt = r_taken_cnt;
    w_flush_cnt_nxt = r_flush ? sat_inc(r_flush_cnt) : r_flush_cnt;

    unique case (r_state)
      ST_RUN: begin
        w_flush_nxt = 1'b0;
        if (w_redirect) begin
          // A redirect also overrides a stall: the stalled work is wrong-path.
          w_fcnt_nxt  = FCNT_INIT;
          w_flush_nxt = 1'b1;
          if (w_aligned) begin
            w_pc_nxt        = br_target[PC_W-1:0];
            w_state_nxt     = ST_FLUSH;
            w_taken_cnt_nxt = sat_inc(r_taken_cnt);
          end else begin
            w_pc_nxt       = TRAP_VEC;
            w_state_nxt    = ST_TRAP;
            w_misalign_nxt = 1'b1;
          end
        end
      end
      ST_FLUSH, ST_TRAP: begin
        if (r_fcnt == 3'd0) begin
          w_state_nxt = ST_RUN;
          w_flush_nxt = 1'b0;
        end else begin
          w_fcnt_nxt = r_fcnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_flush_nxt = 1'b0;
      end
    endcase
  end

  assign pc           = r_pc;
  assign flush_if_id  = r_flush;
  assign flush_id_ex  = r_flush;
  assign in_flush     = (r_state != ST_RUN);
  assign misalign_err = r_misalign;
  assign taken_cnt    = r_taken_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
module tb_pc_redirect_ctrl;

  localparam int             PC_W         = 9;
  localparam int             FLUSH_CYCLES = 2;
  localparam logic [PC_W-1:0] TRAP_VEC    = 9'h100;
  localparam int             CNT_W        = 4;
  localparam int             CMAX         = (1 << CNT_W) - 1;
  localparam int             PC_MOD       = (1 << PC_W);

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic             ex_valid;
  logic             br_taken;
  logic [31:0]      br_target;
  logic [PC_W-1:0]  pc;
  logic             flush_if_id;
  logic             flush_id_ex;
  logic             in_flush;
  logic             misalign_err;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] flush_cnt;

  pc_redirect_ctrl #(
    .PC_W        (PC_W),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .TRAP_VEC    (TRAP_VEC),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .pc          (pc),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .in_flush    (in_flush),
    .misalign_err(misalign_err),
    .taken_cnt   (taken_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: PC, cycles left in the flush window, sticky error and
  // the two statistics counts.
  int m_pc;
  int m_left;
  int m_mis;
  int m_taken;
  int m_fcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_zero();
    m_pc = 0; m_left = 0; m_mis = 0; m_taken = 0; m_fcnt = 0;
  endtask

  // One rising edge of the model, using the inputs presented to the DUT.
  task automatic model_edge();
    if (reset) begin
      model_zero();
    end else if (m_left > 0) begin
      if (m_fcnt < CMAX) m_fcnt++;
      m_left--;
      if (!stall) m_pc = (m_pc + 4) % PC_MOD;
    end else if (ex_valid && br_taken) begin
      if (br_target[1:0] == 2'b00) begin
        m_pc = int'(br_target[PC_W-1:0]);
        if (m_taken < CMAX) m_taken++;
      end else begin
        m_pc  = int'(TRAP_VEC);
        m_mis = 1;
      end
      m_left = FLUSH_CYCLES;
    end else if (!stall) begin
      m_pc = (m_pc + 4) % PC_MOD;
    end
  endtask

  task automatic check_all();
    logic fl;
    fl = (m_left > 0);
    chk("pc",           32'(pc),           32'(m_pc));
    chk("flush_if_id",  32'(flush_if_id),  32'(fl));
    chk("flush_id_ex",  32'(flush_id_ex),  32'(fl));
    chk("in_flush",     32'(in_flush),     32'(fl));
    chk("misalign_err", 32'(misalign_err), 32'(m_mis));
    chk("taken_cnt",    32'(taken_cnt),    32'(m_taken));
    chk("flush_cnt",    32'(flush_cnt),    32'(m_fcnt));
  endtask

  task automatic cycle(input logic s, input logic ev, input logic bt, input logic [31:0] tg);
    stall     = s;
    ex_valid  = ev;
    br_taken  = bt;
    br_target = tg;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  // Reset asserted between edges: outputs must clear without waiting for clk.
  task automatic async_reset();
    reset = 1'b1;
    #2;
    model_zero();
    check_all();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] tg;
    reset = 1'b1; stall = 1'b0; ex_valid = 1'b0; br_taken = 1'b0; br_target = '0;
    model_zero();
    @(posedge clk);
    #1;
    check_all();
    chk("reset_pc", 32'(pc), 32'h0);
    reset = 1'b0;

    // Free run: pc 4,8,12,16.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pc_at_0x10", 32'(pc), 32'h10);

    // Aligned redirect to 0x40, then the two-cycle flush window.
    cycle(1'b0, 1'b1, 1'b1, 32'h40);
    chk("redirect_pc", 32'(pc), 32'h40);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("after_window_pc", 32'(pc), 32'h48);
    chk("after_window_flush_cnt", 32'(flush_cnt), 32'd2);
    chk("after_window_taken_cnt", 32'(taken_cnt), 32'd1);

    // Redirect beats stall; stall alone holds the PC.
    cycle(1'b1, 1'b1, 1'b1, 32'h80);
    chk("stall_redirect_pc", 32'(pc), 32'h80);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_hold_pc", 32'(pc), 32'h80);

    // Misaligned target traps, error is sticky, taken count unchanged.
    cycle(1'b0, 1'b1, 1'b1, 32'h42);
    chk("trap_pc", 32'(pc), 32'(TRAP_VEC));
    chk("trap_taken_cnt", 32'(taken_cnt), 32'd2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("misalign_sticky", 32'(misalign_err), 32'd1);

    // Redirects presented during the window are ignored; counters saturate.
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 32'h1C0 + 32'(i * 4));
      cycle(1'b0, 1'b1, 1'b1, 32'h010);
      cycle(1'b0, 1'b1, 1'b1, 32'h020);
    end
    chk("taken_saturated", 32'(taken_cnt), 32'(CMAX));
    chk("flush_saturated", 32'(flush_cnt), 32'(CMAX));

    // Reset in the middle of a flush window.
    cycle(1'b0, 1'b1, 1'b1, 32'h120);
    async_reset();

    // Wrap: redirect to 0x1F8, run through 0x1FC into 0x000.
    cycle(1'b0, 1'b1, 1'b1, 32'hFFFF_F1F8);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pc_1fc", 32'(pc), 32'h1FC);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pc_wrap", 32'(pc), 32'h0);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        async_reset();
      end else begin
        tg = $urandom;
        if ($urandom_range(0, 3) != 0) tg[1:0] = 2'b00;
        cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), tg);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
